// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and constants for the reorder buffer
package rob_pkg;

    localparam int ROB_WIDTH_DEFAULT = 3;
    // Top bit set: an index value that can never name a live entry
    localparam int NON_DEP = 1 << ROB_WIDTH_DEFAULT;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2,
        TYPE_EXIT   = 2'd3
    } rob_type_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_STORE = 2'd1,
        ST_FLUSHED    = 2'd2
    } rob_state_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        taken;
        logic        pred;
        logic [31:0] alt_pc;
    } rob_entry_t;

    function automatic logic is_mispredict(input rob_entry_t e);
        return e.taken != e.pred;
    endfunction

endpackage

// File: rtl/rob_entry_array.sv
// rtl/rob_entry_array.sv - entry storage: issue and CDB write ports, head and query read ports
module rob_entry_array
    import rob_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 issue_we,
    input  logic [RoB_WIDTH-1:0] issue_index,
    input  rob_entry_t           issue_entry,
    input  logic                 cdb_we,
    input  logic [RoB_WIDTH-1:0] cdb_index,
    input  logic [31:0]          cdb_value,
    input  logic                 cdb_taken,
    input  logic                 retire_we,
    input  logic [RoB_WIDTH-1:0] head_index,
    input  logic                 flush_clr,
    output rob_entry_t           head_entry,
    input  logic [RoB_WIDTH-1:0] query_index,
    output logic                 query_ready,
    output logic [31:0]          query_value
);

    localparam int RoB_SIZE = 1 << RoB_WIDTH;

    rob_entry_t entries [RoB_SIZE];
    logic       query_hit;

    // Issue and retire never target the same slot: full blocks issue, empty blocks retire
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RoB_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (flush_clr) begin
            for (int i = 0; i < RoB_SIZE; i++) begin
                entries[i].busy  <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (cdb_we && entries[cdb_index].busy) begin
                entries[cdb_index].ready <= 1'b1;
                entries[cdb_index].value <= cdb_value;
                entries[cdb_index].taken <= cdb_taken;
            end
            if (issue_we) begin
                entries[issue_index] <= issue_entry;
            end
            if (retire_we) begin
                entries[head_index].busy  <= 1'b0;
                entries[head_index].ready <= 1'b0;
            end
        end
    end

    assign head_entry = entries[head_index];

    // Same-cycle CDB result is forwarded so the Dispatcher need not wait a cycle
    assign query_hit   = cdb_we && (cdb_index == query_index) && entries[query_index].busy;
    assign query_ready = query_hit || (entries[query_index].busy && entries[query_index].ready);
    assign query_value = query_hit ? cdb_value : entries[query_index].value;

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order reorder buffer with commit FSM
// ROB_COMMIT_TRACE_EN: print a per-retire trace (simulation only)
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_en,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_pred_taken,
    input  logic [31:0]          issue_alt_pc,
    output logic                 rob_full,
    output logic [RoB_WIDTH-1:0] rob_tail,
    input  logic                 cdb_en,
    input  logic [RoB_WIDTH-1:0] cdb_index,
    input  logic [31:0]          cdb_value,
    input  logic                 cdb_taken,
    input  logic [RoB_WIDTH-1:0] query_index,
    output logic                 query_ready,
    output logic [31:0]          query_value,
    output logic                 commit_en,
    output logic [4:0]           commit_reg,
    output logic [RoB_WIDTH-1:0] commit_index,
    output logic [31:0]          commit_data,
    output logic                 store_commit_en,
    output logic [RoB_WIDTH-1:0] store_commit_index,
    input  logic                 store_done_in,
    output logic                 flush_out,
    output logic [31:0]          flush_pc,
    output logic                 halt_out
);

    localparam int RoB_SIZE = 1 << RoB_WIDTH;
    localparam logic [RoB_WIDTH:0] FULL_COUNT = (RoB_WIDTH + 1)'(RoB_SIZE);

    logic [RoB_WIDTH-1:0] head;
    logic [RoB_WIDTH-1:0] tail;
    logic [RoB_WIDTH:0]   count;
    rob_state_e           state;
    rob_state_e           state_nxt;
    rob_entry_t           head_entry;
    rob_entry_t           issue_entry;

    logic issue_we;
    logic cdb_we;
    logic head_ok;
    logic retire;
    logic commit_fire;
    logic store_fire;
    logic flush_fire;
    logic halt_fire;
    logic flush_clr;
    logic commit_en_q;
    logic store_commit_en_q;
    logic flush_q;

    assign rob_full = (count == FULL_COUNT);
    assign rob_tail = tail;

    // Nothing enters the array during the flush cycle; it is about to be wiped
    assign issue_we = rdy_in && issue_en && !rob_full && (state != ST_FLUSHED);
    assign cdb_we   = rdy_in && cdb_en && (state != ST_FLUSHED);

    always_comb begin
        issue_entry        = '0;
        issue_entry.busy   = 1'b1;
        issue_entry.ready  = (rob_type_e'(issue_type) == TYPE_EXIT);
        issue_entry.typ    = rob_type_e'(issue_type);
        issue_entry.rd     = issue_rd;
        issue_entry.pred   = issue_pred_taken;
        issue_entry.alt_pc = issue_alt_pc;
    end

    rob_entry_array #(
        .RoB_WIDTH(RoB_WIDTH)
    ) u_entries (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .issue_we    (issue_we),
        .issue_index (tail),
        .issue_entry (issue_entry),
        .cdb_we      (cdb_we),
        .cdb_index   (cdb_index),
        .cdb_value   (cdb_value),
        .cdb_taken   (cdb_taken),
        .retire_we   (retire),
        .head_index  (head),
        .flush_clr   (flush_clr),
        .head_entry  (head_entry),
        .query_index (query_index),
        .query_ready (query_ready),
        .query_value (query_value)
    );

    // Once halted the head is never considered again until reset
    assign head_ok = (count != '0) && head_entry.busy && head_entry.ready && !halt_out;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (head_ok) begin
                    if (head_entry.typ == TYPE_STORE) begin
                        state_nxt = ST_WAIT_STORE;
                    end else if (head_entry.typ == TYPE_BRANCH && is_mispredict(head_entry)) begin
                        state_nxt = ST_FLUSHED;
                    end
                end
            end
            ST_WAIT_STORE: begin
                if (store_done_in) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLUSHED: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        retire      = 1'b0;
        commit_fire = 1'b0;
        store_fire  = 1'b0;
        flush_fire  = 1'b0;
        halt_fire   = 1'b0;
        flush_clr   = 1'b0;
        if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (head_ok) begin
                        case (head_entry.typ)
                            TYPE_REG: begin
                                retire      = 1'b1;
                                commit_fire = 1'b1;
                            end
                            TYPE_BRANCH: begin
                                retire     = !is_mispredict(head_entry);
                                flush_fire = is_mispredict(head_entry);
                            end
                            TYPE_STORE: store_fire = 1'b1;
                            TYPE_EXIT: begin
                                retire    = 1'b1;
                                halt_fire = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT_STORE: retire    = store_done_in;
                ST_FLUSHED:    flush_clr = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (issue_we) begin
                tail <= tail + RoB_WIDTH'(1);
            end
            if (retire) begin
                head <= head + RoB_WIDTH'(1);
            end
            count <= count + (RoB_WIDTH + 1)'(issue_we) - (RoB_WIDTH + 1)'(retire);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            commit_en_q        <= 1'b0;
            store_commit_en_q  <= 1'b0;
            flush_q            <= 1'b0;
            commit_reg         <= '0;
            commit_index       <= '0;
            commit_data        <= '0;
            store_commit_index <= '0;
            flush_pc           <= '0;
            halt_out           <= 1'b0;
        end else if (rdy_in) begin
            commit_en_q       <= commit_fire;
            store_commit_en_q <= store_fire;
            flush_q           <= flush_fire;
            if (commit_fire) begin
                commit_reg   <= head_entry.rd;
                commit_index <= head;
                commit_data  <= head_entry.value;
            end
            if (store_fire) begin
                store_commit_index <= head;
            end
            if (flush_fire) begin
                flush_pc <= head_entry.alt_pc;
            end
            if (halt_fire) begin
                halt_out <= 1'b1;
            end
        end
    end

    // A pulse held across a stall is shown once, on the first ready cycle
    assign commit_en       = commit_en_q && rdy_in;
    assign store_commit_en = store_commit_en_q && rdy_in;
    assign flush_out       = flush_q && rdy_in;

`ifdef ROB_COMMIT_TRACE_EN
    logic [63:0] cycle_cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (retire || flush_fire) begin
                $display("%0d idx=%0d type=%0d rd=%0d value=%08h mispredict=%0d",
                         cycle_cnt, head, head_entry.typ, head_entry.rd, head_entry.value,
                         flush_fire);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed bench with an in-order retirement scoreboard
module tb_reorder_buffer;

    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;
    localparam logic [1:0] T_EXIT   = 2'd3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_en;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic        issue_pred_taken;
    logic [31:0] issue_alt_pc;
    logic        rob_full;
    logic [2:0]  rob_tail;
    logic        cdb_en;
    logic [2:0]  cdb_index;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [2:0]  query_index;
    logic        query_ready;
    logic [31:0] query_value;
    logic        commit_en;
    logic [4:0]  commit_reg;
    logic [2:0]  commit_index;
    logic [31:0] commit_data;
    logic        store_commit_en;
    logic [2:0]  store_commit_index;
    logic        store_done_in;
    logic        flush_out;
    logic [31:0] flush_pc;
    logic        halt_out;

    reorder_buffer #(.RoB_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_en(issue_en), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .rob_full(rob_full), .rob_tail(rob_tail),
        .cdb_en(cdb_en), .cdb_index(cdb_index), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .query_index(query_index), .query_ready(query_ready), .query_value(query_value),
        .commit_en(commit_en), .commit_reg(commit_reg), .commit_index(commit_index),
        .commit_data(commit_data), .store_commit_en(store_commit_en),
        .store_commit_index(store_commit_index), .store_done_in(store_done_in),
        .flush_out(flush_out), .flush_pc(flush_pc), .halt_out(halt_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          idx;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        pred;
        logic        taken;
        logic [31:0] alt;
        logic        done;
    } mentry_t;

    mentry_t exp_q[$];
    int      model_tail;
    int      total;
    int      bad;
    int      n_commit;
    int      n_store;
    int      n_flush;
    logic    halt_prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic bad_event(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got event at index %0d want none (in-order rule)", nm, act);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_en      = 1'b0;
        cdb_en        = 1'b0;
        store_done_in = 1'b0;
    endtask

    task automatic issue_set(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] val,
                             input logic pred, input logic taken, input logic [31:0] alt);
        mentry_t e;
        e.idx = model_tail; e.typ = t; e.rd = rd; e.val = val;
        e.pred = pred; e.taken = taken; e.alt = alt; e.done = (t == T_EXIT);
        exp_q.push_back(e);
        model_tail = (model_tail + 1) % 8;
        issue_en = 1'b1; issue_type = t; issue_rd = rd;
        issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    task automatic cdb_set(input int idx);
        int k = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].idx == idx) k = j;
        end
        cdb_en    = 1'b1;
        cdb_index = 3'(idx);
        if (k >= 0) begin
            exp_q[k].done = 1'b1;
            cdb_value     = exp_q[k].val;
            cdb_taken     = exp_q[k].taken;
        end
    endtask

    task automatic pop_silent();
        while (exp_q.size() > 0 && exp_q[0].typ == T_BRANCH && exp_q[0].done &&
               exp_q[0].pred == exp_q[0].taken) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every visible retirement event must match the oldest live entry
    always @(negedge clk_in) begin
        if (!rst_in) begin
            halt_prev = 1'b0;
        end else begin
            if (commit_en) begin
                n_commit++;
                pop_silent();
                if (exp_q.size() > 0 && exp_q[0].typ == T_REG && exp_q[0].done) begin
                    chk("commit_index", 32'(commit_index), 32'(exp_q[0].idx));
                    chk("commit_reg", 32'(commit_reg), 32'(exp_q[0].rd));
                    chk("commit_data", commit_data, exp_q[0].val);
                    void'(exp_q.pop_front());
                end else begin
                    bad_event("commit_order", 32'(commit_index));
                end
            end
            if (store_commit_en) begin
                n_store++;
                pop_silent();
                if (exp_q.size() > 0 && exp_q[0].typ == T_STORE && exp_q[0].done) begin
                    chk("store_index", 32'(store_commit_index), 32'(exp_q[0].idx));
                    void'(exp_q.pop_front());
                end else begin
                    bad_event("store_order", 32'(store_commit_index));
                end
            end
            if (flush_out) begin
                n_flush++;
                pop_silent();
                if (exp_q.size() > 0 && exp_q[0].typ == T_BRANCH && exp_q[0].done &&
                    exp_q[0].pred != exp_q[0].taken) begin
                    chk("flush_pc_sb", flush_pc, exp_q[0].alt);
                    exp_q.delete();
                    model_tail = 0;
                end else begin
                    bad_event("flush_order", flush_pc);
                end
            end
            if (halt_out && !halt_prev) begin
                pop_silent();
                if (exp_q.size() > 0 && exp_q[0].typ == T_EXIT) begin
                    void'(exp_q.pop_front());
                end else begin
                    bad_event("halt_order", 32'd0);
                end
            end
            halt_prev = halt_out;
        end
    end

    initial begin
        int n;
        total = 0; bad = 0; n_commit = 0; n_store = 0; n_flush = 0;
        model_tail = 0; halt_prev = 1'b0;
        rst_in = 1'b0; rdy_in = 1'b1;
        idle();
        issue_type = 2'd0; issue_rd = 5'd0; issue_pred_taken = 1'b0; issue_alt_pc = 32'd0;
        cdb_index = 3'd0; cdb_value = 32'd0; cdb_taken = 1'b0; query_index = 3'd0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();

        chk("rst_tail", 32'(rob_tail), 32'd0);
        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_commit", 32'(commit_en), 32'd0);
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_halt", 32'(halt_out), 32'd0);
        chk("rst_store", 32'(store_commit_en), 32'd0);
        #1;
        chk("rst_query", 32'(query_ready), 32'd0);

        // reset in the middle of operation, with entry 0 about to commit
        for (int i = 0; i < 3; i++) begin
            issue_set(T_REG, 5'(i + 1), 32'h10 + 32'(i), 1'b0, 1'b0, 32'd0);
            tick();
            idle();
        end
        chk("midrst_tail_before", 32'(rob_tail), 32'd3);
        cdb_set(0);
        tick();
        idle();
        rst_in = 1'b0;
        exp_q.delete();
        model_tail = 0;
        #1;
        chk("midrst_tail", 32'(rob_tail), 32'd0);
        chk("midrst_full", 32'(rob_full), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (5) tick();
        chk("midrst_no_commit", 32'(n_commit), 32'd0);

        // fill all 8, complete the youngest first
        for (int i = 0; i < 8; i++) begin
            issue_set(T_REG, 5'(i + 1), 32'hA000_0000 + 32'(i) * 32'h111, 1'b0, 1'b0, 32'd0);
            tick();
            idle();
        end
        chk("fill_full", 32'(rob_full), 32'd1);
        chk("fill_tail", 32'(rob_tail), 32'd0);
        cdb_set(7);
        tick();
        idle();
        query_index = 3'd7;
        #1;
        chk("fill_query_ready", 32'(query_ready), 32'd1);
        chk("fill_query_value", query_value, 32'hA000_0777);
        tick();
        tick();
        chk("fill_no_early_commit", 32'(n_commit), 32'd0);
        for (int i = 0; i < 7; i++) begin
            cdb_set(i);
            tick();
            idle();
        end
        wait_drain(20, "fill_drain");
        chk("fill_commits", 32'(n_commit), 32'd8);
        chk("fill_not_full", 32'(rob_full), 32'd0);

        // wrap-around: 12 entries streamed, tail passes 7 -> 0
        chk("wrap_tail_start", 32'(rob_tail), 32'd0);
        for (int i = 0; i < 13; i++) begin
            if (i < 12) issue_set(T_REG, 5'(i + 1), 32'hB00 + 32'(i), 1'b0, 1'b0, 32'd0);
            if (i > 0) cdb_set((i - 1) % 8);
            tick();
            idle();
        end
        wait_drain(20, "wrap_drain");
        chk("wrap_commits", 32'(n_commit), 32'd20);
        chk("wrap_tail", 32'(rob_tail), 32'd4);

        // correct branch, then a mispredicted one with ready younger REGs
        issue_set(T_BRANCH, 5'd0, 32'd0, 1'b0, 1'b0, 32'h200);
        tick(); idle();
        issue_set(T_BRANCH, 5'd0, 32'd0, 1'b1, 1'b0, 32'h104);
        tick(); idle();
        issue_set(T_REG, 5'd10, 32'hC6, 1'b0, 1'b0, 32'd0);
        tick(); idle();
        issue_set(T_REG, 5'd11, 32'hC7, 1'b0, 1'b0, 32'd0);
        tick(); idle();
        cdb_set(6); tick(); idle();
        cdb_set(7); tick(); idle();
        cdb_set(4); tick(); idle();
        cdb_set(5); tick(); idle();
        n = 0;
        while (!flush_out && n < 10) begin
            tick();
            n++;
        end
        chk("flush_seen", 32'(flush_out), 32'd1);
        chk("flush_pc", flush_pc, 32'h104);
        tick();
        chk("flush_pulse_one", 32'(flush_out), 32'd0);
        chk("flush_tail", 32'(rob_tail), 32'd0);
        repeat (4) tick();
        chk("flush_no_younger", 32'(n_commit), 32'd20);
        chk("flush_count", 32'(n_flush), 32'd1);

        // store at head, completion delayed by the load/store buffer
        issue_set(T_STORE, 5'd0, 32'h5, 1'b0, 1'b0, 32'd0);
        tick(); idle();
        issue_set(T_REG, 5'd9, 32'h99, 1'b0, 1'b0, 32'd0);
        tick(); idle();
        cdb_set(0); tick(); idle();
        cdb_set(1); tick(); idle();
        n = 0;
        while (!store_commit_en && n < 10) begin
            tick();
            n++;
        end
        chk("store_seen", 32'(store_commit_en), 32'd1);
        chk("store_index", 32'(store_commit_index), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("store_hold_commit", 32'(commit_en), 32'd0);
            chk("store_hold_pulse", 32'(store_commit_en), 32'd0);
        end
        store_done_in = 1'b1;
        tick();
        store_done_in = 1'b0;
        chk("store_done_no_commit_yet", 32'(commit_en), 32'd0);
        tick();
        chk("store_next_commit", 32'(commit_en), 32'd1);
        chk("store_next_data", commit_data, 32'h99);
        chk("store_next_reg", 32'(commit_reg), 32'd9);
        chk("store_next_index", 32'(commit_index), 32'd1);
        chk("store_pulses", 32'(n_store), 32'd1);

        // query bypass, stale query, then EXIT
        issue_set(T_REG, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        tick(); idle();
        query_index = 3'd2;
        #1;
        chk("query_not_ready", 32'(query_ready), 32'd0);
        cdb_set(2);
        #1;
        chk("bypass_ready", 32'(query_ready), 32'd1);
        chk("bypass_value", query_value, 32'hDEAD_BEEF);
        query_index = 3'd3;
        #1;
        chk("stale_query", 32'(query_ready), 32'd0);
        tick();
        idle();
        issue_set(T_EXIT, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick(); idle();
        n = 0;
        while (!halt_out && n < 10) begin
            tick();
            n++;
        end
        chk("halt_set", 32'(halt_out), 32'd1);
        issue_set(T_REG, 5'd4, 32'h44, 1'b0, 1'b0, 32'd0);
        tick(); idle();
        cdb_set(4); tick(); idle();
        repeat (5) tick();
        chk("halt_sticky", 32'(halt_out), 32'd1);
        chk("halt_no_commit", 32'(n_commit), 32'd22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
